// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter/sequencer in front of a single-port, word-addressed data
// memory with combinational read data. One access is granted per cycle; the
// winner drives the memory, and a one-cycle registered response (rvalid,
// rdata, err) is returned to the winning port only. Addresses at or beyond
// DEPTH are rejected: no memory write, err = 1 and rdata = 0 in the response.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin tie-break using a 1-bit last_gnt
//                   undefined -> fixed priority, port 0 wins every tie
//
// Parameters:
//   N      data width in bits
//   AW     address width in bits (word index)
//   DEPTH  number of memory words; valid addresses are 0..DEPTH-1
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   pX_req/we/addr/wdata       request from port X (held until granted)
//   pX_gnt                     combinational accept, same cycle as request
//   pX_rvalid/rdata/err        registered response, one cycle after gnt
//   mem_addr/we/wdata          memory drive for the granted access
//   mem_rdata                  memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int N     = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [N-1:0]  p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [N-1:0]  p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [N-1:0]  p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [N-1:0]  p1_rdata,
    output logic          p1_err,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
);

    // One extra bit so that DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

    // -------------------------------------------------------------------------
    // Per-port views so the response path can be generated once per port
    // -------------------------------------------------------------------------
    logic          req      [2];
    logic          we       [2];
    logic [AW-1:0] addr     [2];
    logic [N-1:0]  wdata    [2];
    logic          in_range [2];
    logic          gnt      [2];
    logic          rvalid_o [2];
    logic          err_o    [2];
    logic [N-1:0]  rdata_o  [2];

    assign req[0]   = p0_req;
    assign req[1]   = p1_req;
    assign we[0]    = p0_we;
    assign we[1]    = p1_we;
    assign addr[0]  = p0_addr;
    assign addr[1]  = p1_addr;
    assign wdata[0] = p0_wdata;
    assign wdata[1] = p1_wdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_range
        assign in_range[gi] = ({1'b0, addr[gi]} < DEPTH_EXT);
    end

    // -------------------------------------------------------------------------
    // Winner selection
    // win_valid : some port is granted this cycle (never during reset)
    // win_sel   : index of the granted port
    // -------------------------------------------------------------------------
    logic win_valid;
    logic win_sel;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_q;
    logic last_gnt_d;
`endif

    always_comb begin
        win_valid = rst_n && (p0_req || p1_req);
        win_sel   = 1'b0;
        if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
            // Tie goes to the port that did not win the most recent grant.
            win_sel = ~last_gnt_q;
`else
            win_sel = 1'b0;
`endif
        end else begin
            win_sel = p1_req;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (win_valid) begin
            last_gnt_d = win_sel;
        end
    end

    // Reset value 1 makes port 0 the winner of the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Memory drive: idle cycles present all-zero so the memory sees no
    // stale address/data from the last access.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (win_valid) begin
            mem_addr  = addr[win_sel];
            mem_wdata = wdata[win_sel];
            mem_we    = we[win_sel] && in_range[win_sel];
        end
    end

    // -------------------------------------------------------------------------
    // Per-port registered response
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam logic PORT_ID = 1'(gi);

        logic          port_gnt;
        logic          rvalid_q;
        logic          rvalid_d;
        logic          err_q;
        logic          err_d;
        logic [N-1:0]  rdata_q;
        logic [N-1:0]  rdata_d;

        assign port_gnt = win_valid && (win_sel == PORT_ID);
        assign gnt[gi]  = port_gnt;

        always_comb begin
            rvalid_d = port_gnt;
            err_d    = port_gnt && !in_range[gi];
            rdata_d  = rdata_q;
            if (port_gnt) begin
                if (!in_range[gi]) begin
                    rdata_d = '0;
                end else if (!we[gi]) begin
                    rdata_d = mem_rdata;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                err_q    <= err_d;
                rdata_q  <= rdata_d;
            end
        end

        // A response whose cycle coincides with reset is dropped: the strobes
        // are qualified by rst_n so the requester never sees a response that
        // belongs to a transaction the reset has abandoned.
        assign rvalid_o[gi] = rvalid_q && rst_n;
        assign err_o[gi]    = err_q && rst_n;
        assign rdata_o[gi]  = rdata_q;
    end

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid_o[0];
    assign p1_rvalid = rvalid_o[1];
    assign p0_err    = err_o[0];
    assign p1_err    = err_o[1];
    assign p0_rdata  = rdata_o[0];
    assign p1_rdata  = rdata_o[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed steps followed by randomized traffic against dmem_arbiter. The
// bench owns a behavioural memory (env_mem) connected to the mem_* pins and a
// separate transaction-level reference (ref_mem plus expected responses).
// Compile with +define+DMEM_ARB_RR_EN to check the round-robin build.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int N     = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int IW    = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic          req_v   [2];
    logic          we_v    [2];
    logic [AW-1:0] addr_v  [2];
    logic [N-1:0]  wdata_v [2];

    logic          p0_req, p1_req, p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [N-1:0]  p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [N-1:0]  p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;

    assign p0_req   = req_v[0];
    assign p1_req   = req_v[1];
    assign p0_we    = we_v[0];
    assign p1_we    = we_v[1];
    assign p0_addr  = addr_v[0];
    assign p1_addr  = addr_v[1];
    assign p0_wdata = wdata_v[0];
    assign p1_wdata = wdata_v[1];

    always #5 clk = ~clk;

    dmem_arbiter #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural memory seen by the DUT; out-of-range reads return a marker
    // so a missing rdata=0 on error shows up.
    logic [N-1:0] env_mem [DEPTH];
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? env_mem[mem_addr[IW-1:0]] : 32'hBAD0_BAD0;

    // Reference model state
    logic [N-1:0] ref_mem    [DEPTH];
    logic         exp_rvalid [2];
    logic         exp_err    [2];
    logic [N-1:0] exp_rdata  [2];
    int           last_win;

    int n_assert = 0;
    int n_fail   = 0;

    // Observations from the most recent cycle
    logic [1:0]    g_obs;
    logic          ew;
    logic [AW-1:0] ea;
    logic [N-1:0]  ed;
    int            last_w;
    logic [N-1:0]  init0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: lone requester wins; on a tie round-robin gives it to
    // the port that did not win last, fixed priority gives it to port 0.
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            return (last_win == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [N-1:0] d);
        req_v[p]   = r;
        we_v[p]    = w;
        addr_v[p]  = a;
        wdata_v[p] = d;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock cycle: check combinational and registered outputs at the
    // falling edge, then advance the reference across the rising edge.
    task automatic cycle(input string tag);
        int         w;
        logic [1:0] g_exp;
        logic       inr;
        @(negedge clk);
        w = rst_n ? pick(req_v[0], req_v[1]) : -1;
        g_exp = 2'b00;
        if (w >= 0) g_exp[w] = 1'b1;
        g_obs = {p1_gnt, p0_gnt};
        chk({tag, ":gnt"}, 32'(g_obs), 32'(g_exp));
        if (w >= 0) begin
            inr = (addr_v[w] < 32'(DEPTH));
            chk({tag, ":mem_we"},    32'(mem_we), 32'(we_v[w] && inr));
            chk({tag, ":mem_addr"},  mem_addr,    addr_v[w]);
            chk({tag, ":mem_wdata"}, mem_wdata,   wdata_v[w]);
        end else begin
            chk({tag, ":mem_we"}, 32'(mem_we), 32'd0);
            if (rst_n) begin
                chk({tag, ":mem_addr0"},  mem_addr,  32'd0);
                chk({tag, ":mem_wdata0"}, mem_wdata, 32'd0);
            end
        end
        chk({tag, ":p0_rvalid"}, 32'(p0_rvalid), 32'(exp_rvalid[0] && rst_n));
        chk({tag, ":p1_rvalid"}, 32'(p1_rvalid), 32'(exp_rvalid[1] && rst_n));
        chk({tag, ":p0_err"},    32'(p0_err),    32'(exp_err[0] && rst_n));
        chk({tag, ":p1_err"},    32'(p1_err),    32'(exp_err[1] && rst_n));
        chk({tag, ":p0_rdata"},  p0_rdata, exp_rdata[0]);
        chk({tag, ":p1_rdata"},  p1_rdata, exp_rdata[1]);
        ew = mem_we;
        ea = mem_addr;
        ed = mem_wdata;

        @(posedge clk);
        #1;
        if (ew) env_mem[ea[IW-1:0]] = ed;

        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                exp_rvalid[p] = 1'b0;
                exp_err[p]    = 1'b0;
                exp_rdata[p]  = '0;
            end
            last_win = 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (p != w) begin
                    exp_rvalid[p] = 1'b0;
                    exp_err[p]    = 1'b0;
                end
            end
            if (w >= 0) begin
                exp_rvalid[w] = 1'b1;
                if (addr_v[w] >= 32'(DEPTH)) begin
                    exp_err[w]   = 1'b1;
                    exp_rdata[w] = '0;
                end else begin
                    exp_err[w] = 1'b0;
                    if (we_v[w]) ref_mem[addr_v[w]] = wdata_v[w];
                    else         exp_rdata[w] = ref_mem[addr_v[w]];
                end
                last_win = w;
                $display("txn t=%0t %s port=%0d %s addr=%h wdata=%h", $time, tag, w,
                         we_v[w] ? "WR" : "RD", addr_v[w], wdata_v[w]);
            end
        end
        last_w = w;
    endtask

    initial begin
        logic [N-1:0] v;
        logic [1:0]   ct_exp [4];

        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        init0 = ref_mem[0];
        for (int p = 0; p < 2; p++) begin
            exp_rvalid[p] = 1'b0;
            exp_err[p]    = 1'b0;
            exp_rdata[p]  = '0;
        end
        last_win = 1;
        last_w   = -1;

        // Reset with both ports requesting: first edge establishes state,
        // then three checked reset cycles.
        rst_n = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'd3, 32'h1111_1111);
        set_port(1, 1'b1, 1'b0, 32'd4, 32'h2222_2222);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cycle("reset");
            chk("reset:p0_rdata_c", p0_rdata, 32'd0);
            chk("reset:p1_rvalid_c", 32'(p1_rvalid), 32'd0);
        end
        rst_n = 1'b1;
        idle();

        // Single port write then read of address 5
        set_port(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        cycle("wr5");
        chk("wr5:p0_gnt", 32'(g_obs), 32'd1);
        set_port(0, 1'b1, 1'b0, 32'd5, 32'h0);
        cycle("rd5");
        chk("rd5:p0_gnt", 32'(g_obs), 32'd1);
        chk("rd5:rvalid", 32'(p0_rvalid), 32'd1);
        chk("rd5:rdata", p0_rdata, 32'hDEAD_BEEF);
        idle();

        // Out-of-range write from port 1, then read address 0
        set_port(1, 1'b1, 1'b1, 32'd1024, 32'h0000_1234);
        cycle("oor");
        chk("oor:mem_we", 32'(ew), 32'd0);
        chk("oor:rvalid", 32'(p1_rvalid), 32'd1);
        chk("oor:err", 32'(p1_err), 32'd1);
        chk("oor:rdata", p1_rdata, 32'd0);
        set_port(1, 1'b1, 1'b0, 32'd0, 32'h0);
        cycle("rd0");
        chk("rd0:rdata", p1_rdata, init0);
        chk("rd0:err", 32'(p1_err), 32'd0);
        idle();

        // Contention: both ports read continuously for four cycles
`ifdef DMEM_ARB_RR_EN
        ct_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        ct_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        set_port(0, 1'b1, 1'b0, 32'd5, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle("contend");
            chk("contend:pattern", 32'(g_obs), 32'(ct_exp[i]));
        end
        idle();

        // Same-cycle write (p0) and read (p1) of address 7
        set_port(0, 1'b1, 1'b1, 32'd7, 32'hA5A5_A5A5);
        set_port(1, 1'b1, 1'b0, 32'd7, 32'h0);
        cycle("wr7");
        chk("wr7:p0_wins", 32'(g_obs), 32'd1);
        set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
        cycle("rd7");
        chk("rd7:p1_gnt", 32'(g_obs), 32'd2);
        chk("rd7:rvalid", 32'(p1_rvalid), 32'd1);
        chk("rd7:rdata", p1_rdata, 32'hA5A5_A5A5);
        idle();

        // Reset right after a read grant drops the response
        set_port(0, 1'b1, 1'b0, 32'd5, 32'h0);
        cycle("drop_rd");
        idle();
        rst_n = 1'b0;
        #1;
        chk("drop:rvalid", 32'(p0_rvalid), 32'd0);
        cycle("drop_rst");
        rst_n = 1'b1;

        // A write granted just before reset still commits
        set_port(0, 1'b1, 1'b1, 32'd9, 32'h0000_0077);
        cycle("wr9");
        idle();
        rst_n = 1'b0;
        cycle("wr9_rst");
        rst_n = 1'b1;
        set_port(0, 1'b1, 1'b0, 32'd9, 32'h0);
        cycle("rd9");
        chk("rd9:rdata", p0_rdata, 32'h0000_0077);
        idle();

        // Randomized traffic; requesters hold until granted
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!req_v[p] && ($urandom_range(0, 99) < 60)) begin
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 4) == 0) ? 32'(DEPTH - 2 + $urandom_range(0, 4))
                                                          : 32'($urandom_range(0, 15)),
                             $urandom);
                end
            end
            cycle("rand");
            if (last_w >= 0) req_v[last_w] = 1'b0;
        end
        rst_n = 1'b1;
        idle();
        cycle("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
